// File: rtl/tcm_port_arbiter_pkg.sv
// Shared types and constants for the TCM port arbiter: widths, requester ids,
// access size encodings and size helpers.
package tcm_port_arbiter_pkg;

    localparam int ADDR_WIDTH        = 32;
    localparam int SIZE_WIDTH        = 3;
    localparam int REG_DATA_WIDTH    = 32;
    localparam int BUS_DATA_WIDTH    = 64;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int FETCH_WIDTH       = 1;
    localparam int FETCH_DATA_WIDTH  = INSTRUCTION_WIDTH * FETCH_WIDTH;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_FETCH = 2'd1,
        REQ_LD    = 2'd2,
        REQ_ST    = 2'd3
    } req_id_e;

    localparam logic [SIZE_WIDTH-1:0] SIZE_LINE = 3'd0;
    localparam logic [SIZE_WIDTH-1:0] SIZE_BYTE = 3'd1;
    localparam logic [SIZE_WIDTH-1:0] SIZE_HALF = 3'd2;
    localparam logic [SIZE_WIDTH-1:0] SIZE_WORD = 3'd4;

    // Bit positions inside the eligible/grant vectors.
    localparam int GNT_FETCH = 0;
    localparam int GNT_LD    = 1;
    localparam int GNT_ST    = 2;

    function automatic logic size_legal(input logic [SIZE_WIDTH-1:0] size);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = 1'b1;
            SIZE_WORD: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [REG_DATA_WIDTH-1:0] size_mask(input logic [SIZE_WIDTH-1:0] size);
        logic [REG_DATA_WIDTH-1:0] m;
        case (size)
            SIZE_BYTE: m = 32'h0000_00FF;
            SIZE_HALF: m = 32'h0000_FFFF;
            SIZE_WORD: m = 32'hFFFF_FFFF;
            default:   m = 32'h0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tcm_arb_pick.sv
// Combinational priority picker: store > load > fetch, with fetch promoted
// to the top when its starvation flag is raised.
module tcm_arb_pick
    import tcm_port_arbiter_pkg::*;
(
    input  logic [2:0] elig_i,
    input  logic       starve_i,
    output logic [2:0] gnt_o
);

    // One-hot grant selection.
    always_comb begin
        gnt_o = 3'b000;
        if (starve_i && elig_i[GNT_FETCH]) begin
            gnt_o[GNT_FETCH] = 1'b1;
        end else if (elig_i[GNT_ST]) begin
            gnt_o[GNT_ST] = 1'b1;
        end else if (elig_i[GNT_LD]) begin
            gnt_o[GNT_LD] = 1'b1;
        end else if (elig_i[GNT_FETCH]) begin
            gnt_o[GNT_FETCH] = 1'b1;
        end else begin
            gnt_o = 3'b000;
        end
    end

endmodule

// File: rtl/tcm_port_arbiter_chk.sv
// Simulation checker for the TCM port arbiter: port command exclusivity,
// single ack per cycle, and reporting of requests with illegal sizes.
module tcm_port_arbiter_chk
    import tcm_port_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req,
    input  logic [SIZE_WIDTH-1:0] ld_size,
    input  logic                  st_req,
    input  logic [SIZE_WIDTH-1:0] st_size,
    input  logic                  tcm_rd,
    input  logic                  tcm_wr,
    input  logic                  fetch_ack,
    input  logic                  ld_ack,
    input  logic                  st_ack,
    output logic [15:0]           illegal_cnt_o
);

    logic illegal_s;

    assign illegal_s = (st_req && !size_legal(st_size)) || (ld_req && !size_legal(ld_size));

    // Counts cycles in which an illegal-size request is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt_o <= 16'd0;
        end else if (illegal_s && (illegal_cnt_o != 16'hFFFF)) begin
            illegal_cnt_o <= illegal_cnt_o + 16'd1;
        end else begin
            illegal_cnt_o <= illegal_cnt_o;
        end
    end

    // Clocked immediate assertions.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(tcm_rd && tcm_wr))
                else $error("tcm_rd and tcm_wr asserted together");
            assert ({1'b0, fetch_ack} + {1'b0, ld_ack} + {1'b0, st_ack} <= 2'd1)
                else $error("more than one ack in a cycle");
            assert (!(st_req && !size_legal(st_size)))
                else $warning("st_req with illegal st_size %0d is never granted", st_size);
            assert (!(ld_req && !size_legal(ld_size)))
                else $warning("ld_req with illegal ld_size %0d is never granted", ld_size);
        end
    end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Single-port TCM arbiter for fetch, store-buffer load and store-buffer store.
// One access per cycle, read data returns one cycle after issue.
module tcm_port_arbiter
    import tcm_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)
(
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        fetch_req,
    input  logic [ADDR_WIDTH-1:0]       fetch_addr,
    output logic                        fetch_ack,
    output logic [FETCH_DATA_WIDTH-1:0] fetch_data,

    input  logic                        ld_req,
    input  logic [ADDR_WIDTH-1:0]       ld_addr,
    input  logic [SIZE_WIDTH-1:0]       ld_size,
    output logic                        ld_ack,
    output logic [REG_DATA_WIDTH-1:0]   ld_data,

    input  logic                        st_req,
    input  logic [ADDR_WIDTH-1:0]       st_addr,
    input  logic [SIZE_WIDTH-1:0]       st_size,
    input  logic [REG_DATA_WIDTH-1:0]   st_data,
    output logic                        st_ack,

    output logic                        tcm_rd,
    output logic                        tcm_wr,
    output logic [ADDR_WIDTH-1:0]       tcm_addr,
    output logic [SIZE_WIDTH-1:0]       tcm_size,
    output logic [REG_DATA_WIDTH-1:0]   tcm_wdata,
    input  logic [BUS_DATA_WIDTH-1:0]   tcm_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [2:0]                elig_s;
    logic [2:0]                pick_s;
    logic [2:0]                gnt_s;
    logic                      starve_s;
    req_id_e                   pend_q;
    req_id_e                   pend_d;
    logic [SIZE_WIDTH-1:0]     ld_size_q;
    logic [SIZE_WIDTH-1:0]     ld_size_d;
    logic [3:0]                starve_q;
    logic [3:0]                starve_d;
    logic                      unused_rdata_s;

    assign unused_rdata_s = ^tcm_rdata[BUS_DATA_WIDTH-1:REG_DATA_WIDTH];

    // Requests are eligible unless their size is illegal or they are in their ack cycle.
    always_comb begin
        elig_s            = 3'b000;
        elig_s[GNT_FETCH] = fetch_req && (pend_q != REQ_FETCH);
        elig_s[GNT_LD]    = ld_req && size_legal(ld_size) && (pend_q != REQ_LD);
        elig_s[GNT_ST]    = st_req && size_legal(st_size) && (pend_q != REQ_ST);
    end

    assign starve_s = (starve_q == STARVE_MAX);

    tcm_arb_pick u_pick (
        .elig_i   (elig_s),
        .starve_i (starve_s),
        .gnt_o    (pick_s)
    );

    // Nothing is issued while reset is held, even between clock edges.
    assign gnt_s = rst ? 3'b000 : pick_s;

    // Port command driven straight from the granted requester.
    always_comb begin
        tcm_rd    = 1'b0;
        tcm_wr    = 1'b0;
        tcm_addr  = {ADDR_WIDTH{1'b0}};
        tcm_size  = SIZE_LINE;
        tcm_wdata = {REG_DATA_WIDTH{1'b0}};
        if (gnt_s[GNT_ST]) begin
            tcm_wr    = 1'b1;
            tcm_addr  = st_addr;
            tcm_size  = st_size;
            tcm_wdata = st_data;
        end else if (gnt_s[GNT_LD]) begin
            tcm_rd   = 1'b1;
            tcm_addr = ld_addr;
            tcm_size = ld_size;
        end else if (gnt_s[GNT_FETCH]) begin
            tcm_rd   = 1'b1;
            tcm_addr = fetch_addr;
            tcm_size = SIZE_LINE;
        end else begin
            tcm_rd = 1'b0;
        end
    end

    // Next outstanding access, captured load size and fetch starvation count.
    always_comb begin
        pend_d    = REQ_NONE;
        ld_size_d = ld_size_q;
        starve_d  = starve_q;
        if (gnt_s[GNT_ST]) begin
            pend_d = REQ_ST;
        end else if (gnt_s[GNT_LD]) begin
            pend_d    = REQ_LD;
            ld_size_d = ld_size;
        end else if (gnt_s[GNT_FETCH]) begin
            pend_d = REQ_FETCH;
        end else begin
            pend_d = REQ_NONE;
        end
        if (!fetch_req || gnt_s[GNT_FETCH]) begin
            starve_d = 4'd0;
        end else if (elig_s[GNT_FETCH] && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // State registers; reset drops any outstanding access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= REQ_NONE;
            ld_size_q <= SIZE_LINE;
            starve_q  <= 4'd0;
        end else begin
            pend_q    <= pend_d;
            ld_size_q <= ld_size_d;
            starve_q  <= starve_d;
        end
    end

    // Ack and return data for the access issued last cycle.
    always_comb begin
        fetch_ack  = 1'b0;
        fetch_data = {FETCH_DATA_WIDTH{1'b0}};
        ld_ack     = 1'b0;
        ld_data    = {REG_DATA_WIDTH{1'b0}};
        st_ack     = 1'b0;
        case (pend_q)
            REQ_FETCH: begin
                fetch_ack  = 1'b1;
                fetch_data = tcm_rdata[FETCH_DATA_WIDTH-1:0];
            end
            REQ_LD: begin
                ld_ack  = 1'b1;
                ld_data = tcm_rdata[REG_DATA_WIDTH-1:0] & size_mask(ld_size_q);
            end
            REQ_ST: begin
                st_ack = 1'b1;
            end
            default: begin
                fetch_ack = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter: a cycle-level reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_tcm_port_arbiter;
    import tcm_port_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_size;
    logic        ld_ack;
    logic [31:0] ld_data;
    logic        st_req;
    logic [31:0] st_addr;
    logic [2:0]  st_size;
    logic [31:0] st_data;
    logic        st_ack;
    logic        tcm_rd;
    logic        tcm_wr;
    logic [31:0] tcm_addr;
    logic [2:0]  tcm_size;
    logic [31:0] tcm_wdata;
    logic [63:0] tcm_rdata;
    logic [15:0] illegal_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: who was granted last cycle (0 none,1 fetch,2 ld,3 st)
    int who_prev;
    int wait_n;
    int cap_bytes;

    always #5 clk = ~clk;

    tcm_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_ack(ld_ack), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data), .st_ack(st_ack),
        .tcm_rd(tcm_rd), .tcm_wr(tcm_wr), .tcm_addr(tcm_addr), .tcm_size(tcm_size),
        .tcm_wdata(tcm_wdata), .tcm_rdata(tcm_rdata)
    );

    tcm_port_arbiter_chk u_chk (
        .clk(clk), .rst(rst), .ld_req(ld_req), .ld_size(ld_size), .st_req(st_req), .st_size(st_size),
        .tcm_rd(tcm_rd), .tcm_wr(tcm_wr), .fetch_ack(fetch_ack), .ld_ack(ld_ack), .st_ack(st_ack),
        .illegal_cnt_o(illegal_cnt)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] s);
        return (s == 3'd1) || (s == 3'd2) || (s == 3'd4);
    endfunction

    // Who should own the port this cycle, from the arbitration rules.
    function automatic int exp_grant();
        bit ef, el, es;
        if (rst) return 0;
        ef = fetch_req && (who_prev != 1);
        el = ld_req && legal(ld_size) && (who_prev != 2);
        es = st_req && legal(st_size) && (who_prev != 3);
        if (ef && (wait_n >= LIMIT)) return 1;
        if (es) return 3;
        if (el) return 2;
        if (ef) return 1;
        return 0;
    endfunction

    // Model state advance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            who_prev  <= 0;
            wait_n    <= 0;
            cap_bytes <= 0;
        end else begin
            who_prev <= exp_grant();
            if (exp_grant() == 2) cap_bytes <= int'(ld_size);
            if (!fetch_req || exp_grant() == 1) wait_n <= 0;
            else if (who_prev != 1 && wait_n < LIMIT) wait_n <= wait_n + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int g;
        logic [63:0] e_addr, e_size, e_wdata, e_ld;
        g       = exp_grant();
        e_addr  = (g == 1) ? 64'(fetch_addr) : (g == 2) ? 64'(ld_addr) : (g == 3) ? 64'(st_addr) : 64'd0;
        e_size  = (g == 2) ? 64'(ld_size) : (g == 3) ? 64'(st_size) : 64'd0;
        e_wdata = (g == 3) ? 64'(st_data) : 64'd0;
        e_ld    = (who_prev == 2) ? (64'(tcm_rdata[31:0]) % (64'd1 << (8 * cap_bytes))) : 64'd0;
        chk("m_tcm_rd",    64'(tcm_rd),    64'((g == 1) || (g == 2)));
        chk("m_tcm_wr",    64'(tcm_wr),    64'(g == 3));
        chk("m_tcm_addr",  64'(tcm_addr),  e_addr);
        chk("m_tcm_size",  64'(tcm_size),  e_size);
        chk("m_tcm_wdata", 64'(tcm_wdata), e_wdata);
        chk("m_fetch_ack", 64'(fetch_ack), 64'(who_prev == 1));
        chk("m_ld_ack",    64'(ld_ack),    64'(who_prev == 2));
        chk("m_st_ack",    64'(st_ack),    64'(who_prev == 3));
        chk("m_fetch_data", 64'(fetch_data), (who_prev == 1) ? 64'(tcm_rdata[31:0]) : 64'd0);
        chk("m_ld_data",   64'(ld_data),   e_ld);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ld_exp [3];
        logic [2:0]  ld_sz  [3];
        ld_exp[0] = 32'h0000_00DD; ld_exp[1] = 32'h0000_CCDD; ld_exp[2] = 32'hAABB_CCDD;
        ld_sz[0]  = 3'd1;          ld_sz[1]  = 3'd2;          ld_sz[2]  = 3'd4;

        rst = 1'b1;
        fetch_req = 1'b0; fetch_addr = 32'h0;
        ld_req = 1'b0; ld_addr = 32'h0; ld_size = 3'd4;
        st_req = 1'b0; st_addr = 32'h0; st_size = 3'd4; st_data = 32'h0;
        tcm_rdata = 64'h0;
        tick(); tick();
        at_neg();
        chk("reset_outputs", 64'({tcm_rd, tcm_wr, fetch_ack, ld_ack, st_ack}), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // single fetch
        fetch_req = 1'b1; fetch_addr = 32'h100; tcm_rdata = 64'hCAFE_BABE_1122_3344;
        at_neg();
        chk("fetch_rd", 64'(tcm_rd), 64'd1);
        chk("fetch_addr", 64'(tcm_addr), 64'h100);
        tick();
        at_neg();
        chk("fetch_ack", 64'(fetch_ack), 64'd1);
        chk("fetch_data", 64'(fetch_data), 64'h1122_3344);
        tick();
        fetch_req = 1'b0;
        tick();

        // all three at once
        st_req = 1'b1; st_addr = 32'h200; st_size = 3'd4; st_data = 32'hDEAD_BEEF;
        ld_req = 1'b1; ld_addr = 32'h300; ld_size = 3'd4;
        fetch_req = 1'b1; fetch_addr = 32'h400; tcm_rdata = 64'h0000_0000_5566_7788;
        at_neg();
        chk("all3_n_wr", 64'({tcm_wr, tcm_addr}), {31'd0, 1'b1, 32'h200});
        tick();
        at_neg();
        chk("all3_n1_st_ack", 64'(st_ack), 64'd1);
        chk("all3_n1_ld_rd", 64'({tcm_rd, tcm_addr}), {31'd0, 1'b1, 32'h300});
        tick();
        st_req = 1'b0;
        at_neg();
        chk("all3_n2_ld_ack", 64'(ld_ack), 64'd1);
        chk("all3_n2_fetch_rd", 64'({tcm_rd, tcm_addr}), {31'd0, 1'b1, 32'h400});
        tick();
        ld_req = 1'b0;
        at_neg();
        chk("all3_n3_fetch_ack", 64'(fetch_ack), 64'd1);
        tick();
        fetch_req = 1'b0;
        tick();

        // load size masking
        tcm_rdata = 64'h1234_5678_AABB_CCDD;
        for (int i = 0; i < 3; i++) begin
            ld_req = 1'b1; ld_addr = 32'h500 + 32'(i); ld_size = ld_sz[i];
            at_neg();
            chk("ld_size_rd", 64'(tcm_rd), 64'd1);
            tick();
            at_neg();
            chk("ld_size_data", 64'(ld_data), 64'(ld_exp[i]));
            tick();
            ld_req = 1'b0;
            tick();
        end

        // starvation: fetch wins at cycles 4 and 10 under alternating st/ld
        st_req = 1'b1; st_addr = 32'h600; st_size = 3'd2; st_data = 32'h0000_ABCD;
        ld_req = 1'b1; ld_addr = 32'h700; ld_size = 3'd1;
        fetch_req = 1'b1; fetch_addr = 32'h800;
        for (int c = 0; c < 12; c++) begin
            at_neg();
            chk("starve_fetch_win", 64'(tcm_rd && (tcm_addr == 32'h800)), 64'((c == 4) || (c == 10)));
            tick();
        end
        st_req = 1'b0; ld_req = 1'b0; fetch_req = 1'b0;
        tick(); tick();

        // asynchronous reset in the ack cycle of a load
        ld_req = 1'b1; ld_addr = 32'h900; ld_size = 3'd4; tcm_rdata = 64'h0000_0000_0BAD_F00D;
        at_neg();
        chk("rstmid_grant", 64'(tcm_rd), 64'd1);
        tick();
        #1 rst = 1'b1;
        #1;
        chk("rstmid_outputs", 64'({tcm_rd, tcm_wr, fetch_ack, ld_ack, st_ack, ld_data}), 64'd0);
        #1 rst = 1'b0;
        at_neg();
        chk("rstmid_no_ack", 64'(ld_ack), 64'd0);
        chk("rstmid_regrant", 64'({tcm_rd, tcm_addr}), {31'd0, 1'b1, 32'h900});
        tick();
        at_neg();
        chk("rstmid_ack", 64'({ld_ack, ld_data}), {31'd0, 1'b1, 32'h0BAD_F00D});
        tick();
        ld_req = 1'b0;
        tick();

        // illegal store size: never served, others still are
        st_req = 1'b1; st_addr = 32'hA00; st_size = 3'd3; st_data = 32'h1;
        ld_req = 1'b1; ld_addr = 32'hB00; ld_size = 3'd4;
        fetch_req = 1'b1; fetch_addr = 32'hC00;
        at_neg();
        chk("ill_ld_first", 64'({tcm_rd, tcm_addr}), {31'd0, 1'b1, 32'hB00});
        tick();
        at_neg();
        chk("ill_fetch_next", 64'({tcm_rd, tcm_addr}), {31'd0, 1'b1, 32'hC00});
        tick();
        ld_req = 1'b0;
        tick();
        fetch_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk("ill_no_store", 64'({tcm_wr, st_ack}), 64'd0);
            tick();
        end
        chk("ill_reported", 64'(illegal_cnt != 16'd0), 64'd1);
        st_req = 1'b0;
        tick();

        // legal half-word store
        st_req = 1'b1; st_addr = 32'hD00; st_size = 3'd2; st_data = 32'h0000_BEEF;
        at_neg();
        chk("st_cmd", 64'({tcm_wr, tcm_size, tcm_wdata}), {28'd0, 1'b1, 3'd2, 32'h0000_BEEF});
        tick();
        at_neg();
        chk("st_ack", 64'(st_ack), 64'd1);
        tick();
        st_req = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
